// File: rtl/vec_mem_responder_if.sv
// Request/memory/response signal bundle for vec_mem_responder.
// The responder uses the slave modport; the requester and RAM use the master modport.
interface vec_mem_responder_if #(
    parameter int LANES  = 16,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 19
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_write;
    logic [ADDR_W-1:0]         req_addr;
    logic [LANES*DATA_W-1:0]   req_wdata;
    logic [ADDR_W-1:0]         mem_addr;
    logic                      mem_we;
    logic                      mem_re;
    logic [DATA_W-1:0]         mem_wdata;
    logic [DATA_W-1:0]         mem_rdata;
    logic                      resp_valid;
    logic [LANES*DATA_W-1:0]   resp_rdata;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, mem_rdata,
        output req_ready, mem_addr, mem_we, mem_re, mem_wdata, resp_valid, resp_rdata
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata, mem_rdata,
        input  req_ready, mem_addr, mem_we, mem_re, mem_wdata, resp_valid, resp_rdata
    );
endinterface

// File: rtl/vec_mem_responder.sv
// Serialises one vector load/store burst into LANES single-word RAM accesses,
// then pulses resp_valid; loads gather the read words into resp_rdata.
module vec_mem_responder #(
    parameter int LANES  = 16,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 19
) (
    input  logic               clk,
    input  logic               rst,
    vec_mem_responder_if.slave bus
);
    localparam int                IDX_W    = $clog2(LANES);
    localparam int                VEC_W    = LANES * DATA_W;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(LANES - 1);

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q,   idx_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [VEC_W-1:0]  wvec_q,  wvec_d;
    logic [DATA_W-1:0] wbyte_q, wbyte_d;
    logic [VEC_W-1:0]  rvec_q,  rvec_d;

    always_comb begin
        // NOTE: every next-state and output gets a default here, so no branch can infer a latch.
        state_d         = state_q;
        idx_d           = idx_q;
        addr_d          = addr_q;
        wvec_d          = wvec_q;
        wbyte_d         = wbyte_q;
        rvec_d          = rvec_q;
        bus.req_ready   = 1'b0;
        bus.mem_we      = 1'b0;
        bus.mem_re      = 1'b0;
        bus.resp_valid  = 1'b0;

        case (state_q)
            IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    idx_d  = '0;
                    addr_d = bus.req_addr;
                    wvec_d = bus.req_wdata;
                    if (bus.req_write) begin
                        wbyte_d = bus.req_wdata[DATA_W-1:0];
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            WRITE: begin
                bus.mem_we = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    addr_d  = addr_q + 1'b1;
                    wbyte_d = wvec_q[int'(idx_d) * DATA_W +: DATA_W];
                end
            end
            READ: begin
                bus.mem_re = 1'b1;
                // RAM data lags the strobe by one cycle, so this cycle returns the previous lane.
                if (idx_q != '0) begin
                    rvec_d[(int'(idx_q) - 1) * DATA_W +: DATA_W] = bus.mem_rdata;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = DRAIN;
                end else begin
                    idx_d  = idx_q + 1'b1;
                    addr_d = addr_q + 1'b1;
                end
            end
            DRAIN: begin
                rvec_d[int'(LAST_IDX) * DATA_W +: DATA_W] = bus.mem_rdata;
                state_d = DONE;
            end
            DONE: begin
                bus.resp_valid = 1'b1;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            addr_q  <= '0;
            wvec_q  <= '0;
            wbyte_q <= '0;
            rvec_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            addr_q  <= addr_d;
            wvec_q  <= wvec_d;
            wbyte_q <= wbyte_d;
            rvec_q  <= rvec_d;
        end
    end

    // Address and write data are registered so they hold their last value outside bursts.
    assign bus.mem_addr   = addr_q;
    assign bus.mem_wdata  = wbyte_q;
    assign bus.resp_rdata = rvec_q;
endmodule

// File: tb/tb_vec_mem_responder.sv
// Self-checking bench for vec_mem_responder: a RAM model plus a transaction-level
// reference that predicts the per-cycle strobe trace and the gathered load vector.
module tb_vec_mem_responder;
    localparam int LANES  = 16;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 19;
    localparam int VW     = LANES * DATA_W;

    typedef struct packed {
        logic              we;
        logic              re;
        logic              rv;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wd;
    } cyc_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vec_mem_responder_if #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    vec_mem_responder #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // RAM model: synchronous write, read data valid the cycle after mem_re; unwritten word[a] = a[7:0].
    logic [DATA_W-1:0] ram [int];
    always @(posedge clk) begin
        if (bus.mem_re)
            bus.mem_rdata <= ram.exists(int'(bus.mem_addr)) ? ram[int'(bus.mem_addr)] : bus.mem_addr[DATA_W-1:0];
        if (bus.mem_we)
            ram[int'(bus.mem_addr)] = bus.mem_wdata;
    end

    // Reference model state.
    logic [DATA_W-1:0] ref_mem [int];
    logic [VW-1:0]     exp_vec = '0;
    cyc_t              exp_q [$];
    cyc_t              obs_q [$];
    logic [VW-1:0]     rd_log [$];
    int                acc_cyc, done_cyc;

    function automatic logic [DATA_W-1:0] ref_rd(logic [ADDR_W-1:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : a[DATA_W-1:0];
    endfunction

    // Expected cycle trace after acceptance: LANES strobe cycles, a drain cycle for loads, then the done pulse.
    task automatic model_burst(input logic wr, input logic [ADDR_W-1:0] base, input logic [VW-1:0] wv);
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] lane;
        exp_q.delete();
        for (int i = 0; i < LANES; i++) begin
            a    = base + ADDR_W'(i);
            lane = wv[i*DATA_W +: DATA_W];
            if (wr) begin
                exp_q.push_back('{we: 1'b1, re: 1'b0, rv: 1'b0, addr: a, wd: lane});
                ref_mem[int'(a)] = lane;
            end else begin
                exp_q.push_back('{we: 1'b0, re: 1'b1, rv: 1'b0, addr: a, wd: '0});
                exp_vec[i*DATA_W +: DATA_W] = ref_rd(a);
            end
        end
        if (!wr) exp_q.push_back('{we: 1'b0, re: 1'b0, rv: 1'b0, addr: '0, wd: '0});
        exp_q.push_back('{we: 1'b0, re: 1'b0, rv: 1'b1, addr: '0, wd: '0});
    endtask

    // Fields the expected cycle does not constrain are taken from the expectation.
    function automatic cyc_t norm(cyc_t o, cyc_t e);
        cyc_t n = o;
        if (!(e.we || e.re)) n.addr = e.addr;
        if (!e.we) n.wd = e.wd;
        return n;
    endfunction

    function automatic int trace_errs(output int first);
        int n = 0;
        first = -1;
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            if (norm(obs_q[i], exp_q[i]) !== exp_q[i]) begin
                n++;
                if (first < 0) first = i;
            end
        return n;
    endfunction

    function automatic int hold_errs();
        int n = 0;
        foreach (rd_log[i]) if (rd_log[i] !== exp_vec) n++;
        return n;
    endfunction

    // Issue one request and record every cycle until resp_valid (bounded).
    task automatic run_burst(input logic wr, input logic [ADDR_W-1:0] base, input logic [VW-1:0] wv,
                             input bit keep, input logic nwr, input logic [ADDR_W-1:0] nbase);
        bit got = 0;
        obs_q.delete();
        rd_log.delete();
        bus.req_write = wr;
        bus.req_addr  = base;
        bus.req_wdata = wv;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (bus.req_ready === 1'b1) got = 1;
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL accept: req_ready never seen, got 0 want 1");
            bus.req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        acc_cyc = cyc;
        if (keep) begin
            bus.req_write = nwr;
            bus.req_addr  = nbase;
            bus.req_wdata = {$urandom, $urandom, $urandom, $urandom};
        end else begin
            bus.req_valid = 1'b0;
            bus.req_write = 1'($urandom);
            bus.req_addr  = ADDR_W'($urandom);
            bus.req_wdata = {$urandom, $urandom, $urandom, $urandom};
        end
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            obs_q.push_back('{we: bus.mem_we, re: bus.mem_re, rv: bus.resp_valid,
                              addr: bus.mem_addr, wd: bus.mem_wdata});
            rd_log.push_back(bus.resp_rdata);
            if (bus.resp_valid === 1'b1) begin
                done_cyc = cyc;
                break;
            end
        end
    endtask

    function automatic logic [VW-1:0] rand_vec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic test_reset();
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        #2;
        checks++;
        if ({bus.mem_we, bus.mem_re, bus.resp_valid} !== 3'b000) begin
            failures++;
            $display("FAIL reset_strobes: got %b want 000", {bus.mem_we, bus.mem_re, bus.resp_valid});
        end
        checks++;
        if ({bus.mem_addr, bus.mem_wdata} !== '0) begin
            failures++;
            $display("FAIL reset_addr_data: got %h/%h want 0/0", bus.mem_addr, bus.mem_wdata);
        end
        checks++;
        if (bus.resp_rdata !== '0) begin
            failures++;
            $display("FAIL reset_rdata: got %h want 0", bus.resp_rdata);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.req_ready, bus.mem_we, bus.mem_re} !== 3'b100) begin
            failures++;
            $display("FAIL reset_release: ready/we/re got %b want 100", {bus.req_ready, bus.mem_we, bus.mem_re});
        end
    endtask

    // One burst through model and DUT with trace, latency and data/hold checks.
    task automatic test_burst(input string name, input logic wr, input logic [ADDR_W-1:0] base, input logic [VW-1:0] wv);
        int nb, fi;
        model_burst(wr, base, wv);
        run_burst(wr, base, wv, 1'b0, 1'b0, '0);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL %s_latency: got %0d cycles want %0d", name, obs_q.size(), exp_q.size());
        end
        checks++;
        nb = trace_errs(fi);
        if (nb != 0) begin
            failures++;
            $display("FAIL %s_trace: %0d bad cycles, first %0d got %h want %h", name, nb, fi, obs_q[fi], exp_q[fi]);
        end
        checks++;
        if (wr) begin
            nb = hold_errs();
            if (nb != 0) begin
                failures++;
                $display("FAIL %s_hold: resp_rdata changed in %0d cycles, got %h want %h", name, nb, rd_log[$], exp_vec);
            end
        end else if (rd_log.size() == 0 || rd_log[$] !== exp_vec) begin
            failures++;
            $display("FAIL %s_rdata: got %h want %h", name, rd_log.size() ? rd_log[$] : '0, exp_vec);
        end
    endtask

    task automatic test_store();
        logic [VW-1:0] v;
        for (int i = 0; i < LANES; i++) v[i*DATA_W +: DATA_W] = DATA_W'(8'hA0 + i);
        test_burst("store", 1'b1, 19'h00100, v);
    endtask

    task automatic test_load();
        test_burst("load", 1'b0, 19'h00200, rand_vec());
    endtask

    task automatic test_wrap();
        test_burst("wrap", 1'b0, 19'h7FFF8, rand_vec());
    endtask

    task automatic test_hold();
        test_burst("hold", 1'b1, 19'h00040, rand_vec());
    endtask

    task automatic test_back_to_back();
        logic [VW-1:0] v = rand_vec();
        int nb, fi, done1;
        model_burst(1'b1, 19'h00500, v);
        run_burst(1'b1, 19'h00500, v, 1'b1, 1'b0, 19'h004F8);
        done1 = done_cyc;
        checks++;
        nb = trace_errs(fi);
        if (nb != 0 || obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL b2b_store_trace: %0d bad, len got %0d want %0d", nb, obs_q.size(), exp_q.size());
        end
        model_burst(1'b0, 19'h004F8, '0);
        run_burst(1'b0, 19'h004F8, bus.req_wdata, 1'b0, 1'b0, '0);
        checks++;
        if (acc_cyc != done1 + 2) begin
            failures++;
            $display("FAIL b2b_accept: accepted at cycle %0d want %0d", acc_cyc, done1 + 2);
        end
        checks++;
        nb = trace_errs(fi);
        if (nb != 0 || obs_q.size() != exp_q.size() || rd_log[$] !== exp_vec) begin
            failures++;
            $display("FAIL b2b_load: %0d bad, len %0d want %0d, rdata got %h want %h",
                     nb, obs_q.size(), exp_q.size(), rd_log[$], exp_vec);
        end
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] base;
        for (int n = 0; n < 12; n++) begin
            base = ($urandom_range(0, 1) == 0) ? ADDR_W'($urandom) : ADDR_W'(19'h7FFF0 + $urandom_range(0, 15));
            test_burst("random", 1'($urandom), base, rand_vec());
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [VW-1:0]     v = rand_vec();
        logic [ADDR_W-1:0] base = 19'h00008;
        bit got = 0;
        bus.req_write = 1'b1;
        bus.req_addr  = base;
        bus.req_wdata = v;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            if (bus.req_ready === 1'b1) got = 1;
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        repeat (8) @(negedge clk);
        checks++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_wdata} !== {1'b1, base + 19'd7, v[7*DATA_W +: DATA_W]}) begin
            failures++;
            $display("FAIL abort_lane7: we/addr/data got %b/%h/%h want 1/%h/%h",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata, base + 19'd7, v[7*DATA_W +: DATA_W]);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.mem_we, bus.mem_re, bus.resp_valid, bus.mem_addr} !== '0) begin
            failures++;
            $display("FAIL abort_async: we/re/rv got %b addr %h want 000 addr 0",
                     {bus.mem_we, bus.mem_re, bus.resp_valid}, bus.mem_addr);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.mem_we, bus.mem_re, bus.resp_valid} !== 3'b000) begin
                failures++;
                $display("FAIL abort_hold: we/re/rv got %b want 000", {bus.mem_we, bus.mem_re, bus.resp_valid});
            end
        end
        rst = 1'b0;
        exp_vec = '0;
        for (int i = 0; i < 7; i++) ref_mem[int'(base + ADDR_W'(i))] = v[i*DATA_W +: DATA_W];
        test_burst("after_abort", 1'b0, 19'h00000, '0);
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_wrap();
        test_hold();
        test_back_to_back();
        test_random();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
